// File: rtl/fpmult_pkg.sv
// Shared encodings for the FPMult exception stage: operand classes, flag bit positions, skid states.
// Pure declarations; no logic, no latency.
package fpmult_pkg;

    localparam logic [1:0] CLS_NORM = 2'b00;
    localparam logic [1:0] CLS_ZERO = 2'b01;
    localparam logic [1:0] CLS_INF  = 2'b10;
    localparam logic [1:0] CLS_NAN  = 2'b11;

    localparam int FLG_INV = 3;
    localparam int FLG_OVF = 2;
    localparam int FLG_UNF = 1;
    localparam int FLG_NX  = 0;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_ONE   = 2'b01,
        SKID_TWO   = 2'b10
    } skid_state_e;

endpackage

// File: rtl/fp_mult_exc_classify.sv
// Combinational special-case/range priority encoder and IEEE packer for the FPMult product.
// Zero latency; no handshake, the parent buffers the result.
module fp_mult_exc_classify
    import fpmult_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 23,
    parameter int FLAG_W = 4
) (
    input  logic [MAN_W-1:0]       round_m_i,
    input  logic [EXP_W+1:0]       round_e_i,
    input  logic                   sgn_i,
    input  logic [1:0]             a_cls_i,
    input  logic [1:0]             b_cls_i,
    input  logic                   rnd_inexact_i,
    output logic [EXP_W+MAN_W:0]   p_o,
    output logic [FLAG_W-1:0]      flags_o
);

    localparam logic signed [EXP_W+1:0] EMAX   = {2'b00, {EXP_W{1'b1}}};
    localparam logic signed [EXP_W+1:0] E_ZERO = '0;
    localparam logic [EXP_W+MAN_W:0]    QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic any_nan, any_inf, any_zero, inf_x_zero;

    assign any_nan    = (a_cls_i == CLS_NAN)  || (b_cls_i == CLS_NAN);
    assign any_inf    = (a_cls_i == CLS_INF)  || (b_cls_i == CLS_INF);
    assign any_zero   = (a_cls_i == CLS_ZERO) || (b_cls_i == CLS_ZERO);
    assign inf_x_zero = any_inf && any_zero;

    always_comb begin
        p_o             = {sgn_i, round_e_i[EXP_W-1:0], round_m_i};
        flags_o         = '0;
        flags_o[FLG_NX] = rnd_inexact_i;
        if (any_nan || inf_x_zero) begin
            p_o              = QNAN;
            flags_o          = '0;
            flags_o[FLG_INV] = 1'b1;
        end else if (any_inf) begin
            p_o     = {sgn_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_o = '0;
        end else if (any_zero) begin
            p_o     = {sgn_i, {(EXP_W+MAN_W){1'b0}}};
            flags_o = '0;
        end else if ($signed(round_e_i) >= EMAX) begin
            p_o              = {sgn_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_o          = '0;
            flags_o[FLG_OVF] = 1'b1;
            flags_o[FLG_NX]  = 1'b1;
        end else if ($signed(round_e_i) <= E_ZERO) begin
            // Subnormals are not produced: anything at or below the minimum exponent flushes to zero.
            p_o              = {sgn_i, {(EXP_W+MAN_W){1'b0}}};
            flags_o          = '0;
            flags_o[FLG_UNF] = 1'b1;
            flags_o[FLG_NX]  = 1'b1;
        end
    end

endmodule

// File: rtl/fp_mult_exception_pipe.sv
// FPMult final stage: classify/pack, then a 2-entry skid buffer; 1-cycle latency, full throughput under backpressure.
// in_ready is registered from buffer state only. FPMULT_EXC_STICKY_EN adds an accumulating sticky flag register.
module fp_mult_exception_pipe
    import fpmult_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 23,
    parameter int FLAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [MAN_W-1:0]       round_m,
    input  logic [EXP_W+1:0]       round_e,
    input  logic                   sgn,
    input  logic [1:0]             a_cls,
    input  logic [1:0]             b_cls,
    input  logic                   rnd_inexact,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   p,
    output logic [FLAG_W-1:0]      flags,
    output logic [FLAG_W-1:0]      sticky,
    input  logic                   sticky_clr
);

    localparam int P_W = 1 + EXP_W + MAN_W;

    logic [P_W-1:0]    cls_p;
    logic [FLAG_W-1:0] cls_flags;

    fp_mult_exc_classify #(
        .EXP_W  (EXP_W),
        .MAN_W  (MAN_W),
        .FLAG_W (FLAG_W)
    ) u_classify (
        .round_m_i     (round_m),
        .round_e_i     (round_e),
        .sgn_i         (sgn),
        .a_cls_i       (a_cls),
        .b_cls_i       (b_cls),
        .rnd_inexact_i (rnd_inexact),
        .p_o           (cls_p),
        .flags_o       (cls_flags)
    );

    skid_state_e       state_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [P_W-1:0]    out_p_q;
    logic [FLAG_W-1:0] out_flags_q;
    logic [P_W-1:0]    skid_p_q;
    logic [FLAG_W-1:0] skid_flags_q;

    logic in_xfer, out_xfer;

    assign in_xfer  = in_valid && in_ready_q;
    assign out_xfer = out_valid_q && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SKID_EMPTY;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_p_q      <= '0;
            out_flags_q  <= '0;
            skid_p_q     <= '0;
            skid_flags_q <= '0;
        end else begin
            case (state_q)
                SKID_EMPTY: begin
                    if (in_xfer) begin
                        out_p_q     <= cls_p;
                        out_flags_q <= cls_flags;
                        out_valid_q <= 1'b1;
                        state_q     <= SKID_ONE;
                    end
                end
                SKID_ONE: begin
                    if (in_xfer && out_xfer) begin
                        out_p_q     <= cls_p;
                        out_flags_q <= cls_flags;
                    end else if (in_xfer) begin
                        // Output is stalled: park the new result so the upstream is not throttled this cycle.
                        skid_p_q     <= cls_p;
                        skid_flags_q <= cls_flags;
                        in_ready_q   <= 1'b0;
                        state_q      <= SKID_TWO;
                    end else if (out_xfer) begin
                        out_valid_q <= 1'b0;
                        state_q     <= SKID_EMPTY;
                    end
                end
                SKID_TWO: begin
                    if (out_xfer) begin
                        out_p_q     <= skid_p_q;
                        out_flags_q <= skid_flags_q;
                        in_ready_q  <= 1'b1;
                        state_q     <= SKID_ONE;
                    end
                end
                default: begin
                    state_q     <= SKID_EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign p         = out_p_q;
    assign flags     = out_flags_q;

`ifdef FPMULT_EXC_STICKY_EN
    logic [FLAG_W-1:0] sticky_q, sticky_d;

    // A clear wins over a same-cycle accumulate; those flags are dropped.
    always_comb begin
        sticky_d = sticky_q;
        if (sticky_clr)
            sticky_d = '0;
        else if (out_xfer)
            sticky_d = sticky_q | out_flags_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sticky_q <= '0;
        else
            sticky_q <= sticky_d;
    end

    assign sticky = sticky_q;
`else
    logic unused_sticky_clr;
    assign unused_sticky_clr = sticky_clr;
    assign sticky            = '0;
`endif

endmodule

// File: tb/tb_fp_mult_exception_pipe.sv
// Scoreboard bench for fp_mult_exception_pipe: random and directed stimulus against a reference model.
module tb_fp_mult_exception_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [22:0] round_m;
    logic [9:0]  round_e;
    logic        sgn;
    logic [1:0]  a_cls;
    logic [1:0]  b_cls;
    logic        rnd_inexact;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] p;
    logic [3:0]  flags;
    logic [3:0]  sticky;
    logic        sticky_clr;

    always #5 clk = ~clk;

    fp_mult_exception_pipe dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .round_m     (round_m),
        .round_e     (round_e),
        .sgn         (sgn),
        .a_cls       (a_cls),
        .b_cls       (b_cls),
        .rnd_inexact (rnd_inexact),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .p           (p),
        .flags       (flags),
        .sticky      (sticky),
        .sticky_clr  (sticky_clr)
    );

    typedef struct packed {
        logic [31:0] p;
        logic [3:0]  f;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;
    logic drv_done;

`ifdef FPMULT_EXC_STICKY_EN
    localparam logic [3:0] STICKY_ACC_EXP = 4'b1101;
`else
    localparam logic [3:0] STICKY_ACC_EXP = 4'b0000;
`endif

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference: IEEE binary32 product selection from operand classes and the signed rounded exponent.
    function automatic exp_t model(input logic [9:0] re, input logic [22:0] rm, input logic s,
                                   input logic [1:0] a, input logic [1:0] b, input logic nx);
        exp_t r;
        int   e;
        bit   nan_op, inf_op, zero_op;
        e       = int'($signed(re));
        nan_op  = (a == 2'd3) || (b == 2'd3);
        inf_op  = (a == 2'd2) || (b == 2'd2);
        zero_op = (a == 2'd1) || (b == 2'd1);
        if (nan_op || (inf_op && zero_op)) begin
            r.p = 32'h7FC0_0000; r.f = 4'b1000;
        end else if (inf_op) begin
            r.p = {s, 31'h7F80_0000}; r.f = 4'b0000;
        end else if (zero_op) begin
            r.p = {s, 31'h0}; r.f = 4'b0000;
        end else if (e >= 255) begin
            r.p = {s, 31'h7F80_0000}; r.f = 4'b0101;
        end else if (e <= 0) begin
            r.p = {s, 31'h0}; r.f = 4'b0011;
        end else begin
            r.p = {s, e[7:0], rm}; r.f = {3'b000, nx};
        end
        return r;
    endfunction

    // Called at posedge+1; holds the request until accepted, then deasserts in_valid after that edge.
    task automatic send(input logic [9:0] re, input logic [22:0] rm, input logic s,
                        input logic [1:0] a, input logic [1:0] b, input logic nx);
        exp_t e;
        int   n;
        e = model(re, rm, s, a, b, nx);
        round_e = re; round_m = rm; sgn = s; a_cls = a; b_cls = b; rnd_inexact = nx;
        in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back(e);
                break;
            end
            n++;
            if (n > 500) begin
                chk("send_timeout", 64'(in_ready), 64'd1);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        chk("drain_empty", 64'(q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic rand_fields(output logic [9:0] re, output logic [22:0] rm, output logic s,
                               output logic [1:0] a, output logic [1:0] b, output logic nx);
        logic [31:0] t;
        int          ev;
        t  = $urandom; rm = t[22:0];
        t  = $urandom; s = t[0]; nx = t[1];
        case ($urandom % 4)
            0: begin t = $urandom; re = t[9:0]; end
            1: begin ev = 250 + int'($urandom_range(0, 10)); re = ev[9:0]; end
            2: begin ev = int'($urandom_range(0, 6)) - 3; re = ev[9:0]; end
            default: begin ev = int'($urandom_range(1, 254)); re = ev[9:0]; end
        endcase
        a = 2'd0; b = 2'd0;
        case ($urandom % 10)
            0: a = 2'd3;
            1: a = 2'd2;
            2: a = 2'd1;
            default: a = 2'd0;
        endcase
        case ($urandom % 10)
            0: b = 2'd3;
            1: b = 2'd2;
            2: b = 2'd1;
            default: b = 2'd0;
        endcase
    endtask

    // Monitor: pops expected results on every output transfer, checks hold-under-stall and sticky.
    logic        hold_pend;
    logic [31:0] hold_p;
    logic [3:0]  hold_f;
    logic [3:0]  m_sticky;
    logic [3:0]  got_f;
    exp_t        me;

    always @(negedge clk) begin
        if (!mon_en) begin
            hold_pend = 1'b0;
            m_sticky  = 4'b0;
        end else begin
            if (hold_pend) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_p", 64'(p), 64'(hold_p));
                chk("hold_flags", 64'(flags), 64'(hold_f));
            end
            hold_pend = out_valid && !out_ready;
            hold_p    = p;
            hold_f    = flags;
            got_f     = 4'b0;
            if (out_valid && out_ready) begin
                chk("out_expected", 64'(q.size() != 0), 64'd1);
                if (q.size() != 0) begin
                    me = q.pop_front();
                    chk("out_p", 64'(p), 64'(me.p));
                    chk("out_flags", 64'(flags), 64'(me.f));
                    got_f = me.f;
                end
            end
`ifdef FPMULT_EXC_STICKY_EN
            chk("sticky_model", 64'(sticky), 64'(m_sticky));
            if (sticky_clr)
                m_sticky = 4'b0;
            else if (out_valid && out_ready)
                m_sticky = m_sticky | got_f;
`else
            chk("sticky_tied", 64'(sticky), 64'd0);
`endif
        end
    end

    initial begin
        logic [9:0]  re;
        logic [22:0] rm;
        logic        s, nx;
        logic [1:0]  a, b;
        exp_t        e;

        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sticky_clr = 1'b0;
        round_m = '0; round_e = '0; sgn = 1'b0; a_cls = 2'd0; b_cls = 2'd0; rnd_inexact = 1'b0;
        drv_done = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_p", 64'(p), 64'd0);
        chk("rst_flags", 64'(flags), 64'd0);
        chk("rst_sticky", 64'(sticky), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        mon_en = 1'b1;
        out_ready = 1'b1;

        // Directed vectors
        send(10'h07F, 23'h400000, 1'b1, 2'd0, 2'd0, 1'b0);
        chk("latency_valid", 64'(out_valid), 64'd1);
        chk("latency_p", 64'(p), 64'hBFC0_0000);
        send(10'h07F, 23'h400000, 1'b1, 2'd2, 2'd1, 1'b0);
        send(10'h07F, 23'h400000, 1'b0, 2'd2, 2'd0, 1'b0);
        send(10'h0FF, 23'h123456, 1'b0, 2'd0, 2'd0, 1'b0);
        send(10'h3FE, 23'h123456, 1'b1, 2'd0, 2'd0, 1'b1);
        send(10'h001, 23'h7FFFFF, 1'b0, 2'd0, 2'd0, 1'b1);
        send(10'h0FE, 23'h000001, 1'b1, 2'd0, 2'd0, 1'b0);
        drain();

        // Backpressure: three back-to-back with the output stalled
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            rand_fields(re, rm, s, a, b, nx);
            e = model(re, rm, s, a, b, nx);
            round_e = re; round_m = rm; sgn = s; a_cls = a; b_cls = b; rnd_inexact = nx;
            in_valid = 1'b1;
            @(negedge clk);
            chk("bp_in_ready_open", 64'(in_ready), 64'd1);
            if (in_ready) q.push_back(e);
            @(posedge clk); #1;
        end
        rand_fields(re, rm, s, a, b, nx);
        round_e = re; round_m = rm; sgn = s; a_cls = a; b_cls = b; rnd_inexact = nx;
        in_valid = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_drop", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        chk("bp_in_ready_still_low", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        send(re, rm, s, a, b, nx);
        drain();

        // Randomised traffic with random output stalls
        fork
            begin
                for (int i = 0; i < 1500; i++) begin
                    if ($urandom % 4 == 0) begin
                        @(posedge clk); #1;
                    end else begin
                        rand_fields(re, rm, s, a, b, nx);
                        send(re, rm, s, a, b, nx);
                    end
                end
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom % 10) < 7;
`ifdef FPMULT_EXC_STICKY_EN
                    sticky_clr = ($urandom % 20) == 0;
`endif
                end
            end
        join
        out_ready = 1'b1;
        sticky_clr = 1'b0;
        drain();

        // Asynchronous reset while both entries are occupied
        out_ready = 1'b0;
        send(10'h080, 23'h0ABCDE, 1'b0, 2'd0, 2'd0, 1'b0);
        send(10'h081, 23'h012345, 1'b1, 2'd0, 2'd0, 1'b1);
        chk("mid_two_in_ready", 64'(in_ready), 64'd0);
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_p", 64'(p), 64'd0);
        chk("mid_rst_flags", 64'(flags), 64'd0);
        q.delete();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mid_rel_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rel_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk("mid_rel_empty", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        mon_en = 1'b1;

        // Sticky accumulation and clear-priority
        send(10'h0FF, 23'h000000, 1'b0, 2'd0, 2'd0, 1'b0);
        send(10'h07F, 23'h000000, 1'b0, 2'd3, 2'd0, 1'b0);
        drain();
        chk("sticky_acc", 64'(sticky), 64'(STICKY_ACC_EXP));
        send(10'h0FF, 23'h000000, 1'b1, 2'd0, 2'd0, 1'b0);
        chk("sticky_clr_setup_valid", 64'(out_valid), 64'd1);
        sticky_clr = 1'b1;
        @(posedge clk); #1;
        sticky_clr = 1'b0;
        chk("sticky_clr_wins", 64'(sticky), 64'd0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fp_mult_exception_pipe.md
Name: fp_mult_exception_pipe

Overview:
- Final stage of the FPMult pipeline. Takes the rounded mantissa/exponent, final sign and operand classes; applies IEEE-754 special-case and range handling; packs the product.
- Parametrised in exponent/mantissa width (binary32 default).
- Registered output with a valid/ready handshake and a 2-entry skid buffer, so full throughput is held under backpressure.
- Emits per-result exception flags.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored mantissa width (no hidden bit).
- FLAG_W, 4, exception flag vector width, fixed: {invalid, overflow, underflow, inexact}.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream result valid.
- in_ready  out  1  block can accept this cycle.
- round_m  in  MAN_W  rounded mantissa.
- round_e  in  EXP_W+2  rounded biased exponent, two's complement; may be negative or exceed the range.
- sgn  in  1  final sign (a.sign XOR b.sign).
- a_cls  in  2  operand A class: 00 normal, 01 zero, 10 inf, 11 NaN.
- b_cls  in  2  operand B class, same encoding.
- rnd_inexact  in  1  rounding discarded nonzero bits.
- out_valid  out  1  p/flags valid.
- out_ready  in  1  downstream accepts.
- p  out  1+EXP_W+MAN_W  packed product {sign, exp, man}.
- flags  out  FLAG_W  exceptions for the current p.
- sticky  out  FLAG_W  accumulated flags (only with the optional feature).
- sticky_clr  in  1  synchronous clear of sticky (only with the optional feature).

Behaviour:
- Reset: async on rst_n low. out_valid=0, p=0, flags=0, sticky=0, buffer empty, in_ready=1 after release.
- Classification (combinational on the input side), first match wins; EMAX = 2^EXP_W-1:
  1. Either operand NaN, or inf×zero → canonical qNaN {0, all-ones, 1 followed by MAN_W-1 zeros}; invalid=1.
  2. Either operand inf → {sgn, all-ones, 0}; no flags.
  3. Either operand zero → {sgn, 0, 0}; no flags.
  4. round_e >= EMAX (signed compare) → {sgn, all-ones, 0}; overflow=1, inexact=1.
  5. round_e <= 0 (signed compare) → flush to {sgn, 0, 0}; underflow=1, inexact=1.
  6. Otherwise → {sgn, round_e[EXP_W-1:0], round_m}; inexact=rnd_inexact.
- Handshake:
  - A transfer occurs when valid&&ready are high at the rising edge.
  - Latency: 1 cycle from input transfer to out_valid.
  - Output data is held stable while out_valid && !out_ready.
- Skid buffer states:
  - EMPTY: in_ready=1, out_valid=0. Input transfer → ONE.
  - ONE: in_ready=1, out_valid=1.
    - Input and output transfer together → stay ONE; new data moves to the output register.
    - Input only → TWO; new data goes to the skid register.
    - Output only → EMPTY.
  - TWO: in_ready=0, out_valid=1. Output transfer → ONE; skid data moves to the output.
- in_ready is a registered function of state only, with no combinational path from out_ready.
- Ordering is strict FIFO; no data is dropped or duplicated.
- Inputs are ignored when in_valid=0, and while in_ready=0.

Optional Feature:
- Macro: FPMULT_EXC_STICKY_EN.
- Defined:
  - sticky |= flags at every output transfer.
  - sticky_clr has priority over a same-cycle OR: the register clears and that cycle's flags are lost.
  - sticky resets to 0.
- Undefined: sticky is tied to 0, sticky_clr is ignored, and no sticky register is inferred.

Decomposition:
- Shared package fpmult_pkg holds:
  - class encoding constants CLS_NORM/CLS_ZERO/CLS_INF/CLS_NAN;
  - flag bit indices FLG_INV=3, FLG_OVF=2, FLG_UNF=1, FLG_NX=0;
  - skid state encoding.
- One natural sub-module: fp_mult_exc_classify, the combinational priority encoder and packer. The parent holds only the skid buffer and the sticky register.

Test Plan:
- Normal pack, defaults: round_e=0x07F, round_m=0x400000, sgn=1, classes 00 → p=0xBFC00000, flags=0000, one cycle after transfer.
- Specials:
  - a_cls=10, b_cls=01 → p=0x7FC00000, flags=1000.
  - a_cls=10, b_cls=00, sgn=0 → p=0x7F800000, flags=0000.
- Range:
  - round_e=0x0FF, sgn=0 → p=0x7F800000, flags=0101.
  - round_e=0x3FE (-2), sgn=1 → p=0x80000000, flags=0011.
- Backpressure: 3 back-to-back inputs with out_ready=0 → in_ready drops after the 2nd is accepted. Raising out_ready then yields all three in order; no loss or duplication.
- Reset mid-operation: assert rst_n=0 while in state TWO → out_valid=0, p=0 immediately (async). After release, in_ready=1 and the buffer is empty.
- FPMULT_EXC_STICKY_EN:
  - After an overflow then an invalid result, sticky=1100 | inexact accumulated.
  - sticky_clr pulsed in the same cycle as a flagged transfer → sticky=0000.
